// File: rtl/wbq_pkg.sv
// Shared types and helpers for the writeback queue.
// The entry data field is sized for the default XLEN. Narrower data
// widths are zero-extended into storage.
package wbq_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int XLEN_DEFAULT = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0]   rd;
    logic [XLEN_DEFAULT-1:0] data;
  } wbq_entry_t;

  // Advance a ring pointer, wrapping at depth (depth is a power of two).
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1) % depth;
  endfunction

endpackage

// File: rtl/wbq_match.sv
// Hazard lookup for one decode source-register port.
// With WBQ_FORWARD_EN defined, it also returns the data of the youngest
// matching entry. Otherwise only the hit flag is produced.
module wbq_match
  import wbq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  wbq_entry_t                 i_entries [DEPTH],
  input  logic [DEPTH-1:0]           i_valid,
  input  logic [$clog2(DEPTH)-1:0]   i_head,
  input  logic [REG_ADDR_W-1:0]      i_query,
  output logic                       o_hit
`ifdef WBQ_FORWARD_EN
  ,
  output logic [XLEN-1:0]            o_data
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  // Walk the entries from oldest to youngest so that the last match seen wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx   = '0;
    o_hit = 1'b0;
`ifdef WBQ_FORWARD_EN
    o_data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = i_head + PTR_W'(k);
      if (i_valid[idx] && (i_query != '0) && (i_entries[idx].rd == i_query)) begin
        o_hit = 1'b1;
`ifdef WBQ_FORWARD_EN
        o_data = XLEN'(i_entries[idx].data);
`endif
      end
    end
  end

`ifndef WBQ_FORWARD_EN
  // Entry data is not needed for a stall-only lookup. Fold it away.
  logic [XLEN-1:0] w_unused_data;
  always_comb begin
    w_unused_data = '0;
    for (int k = 0; k < DEPTH; k++) w_unused_data = w_unused_data ^ XLEN'(i_entries[k].data);
  end
`endif

endmodule

// File: rtl/wb_queue.sv
// In-order writeback queue in front of the register-file write port.
// Optional feature macro: WBQ_FORWARD_EN (adds fwd_rs1/fwd_rs2 data outputs).
// Results that target x0 complete the handshake but are not stored.
module wb_queue
  import wbq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [XLEN-1:0]       in_data,
  input  logic                  wb_stall,
  output logic                  wb_wen,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [XLEN-1:0]       wb_data,
  input  logic [REG_ADDR_W-1:0] q_rs1,
  input  logic [REG_ADDR_W-1:0] q_rs2,
  output logic                  hit_rs1,
  output logic                  hit_rs2
`ifdef WBQ_FORWARD_EN
  ,
  output logic [XLEN-1:0]       fwd_rs1,
  output logic [XLEN-1:0]       fwd_rs2
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wbq_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [DEPTH-1:0]  w_valid;

  // Ready depends only on the registered count, never on a same-cycle pop.
  assign w_empty  = (r_count == '0);
  assign in_ready = (r_count != CNT_W'(DEPTH));
  assign wb_wen   = !w_empty && !wb_stall;
  assign w_pop    = wb_wen;
  assign w_push   = in_valid && in_ready && (in_rd != '0);
  assign wb_addr  = w_empty ? '0 : r_mem[r_head].rd;
  assign wb_data  = w_empty ? '0 : XLEN'(r_mem[r_head].data);

  // Pointer and occupancy update. Pending entries are dropped on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= PTR_W'(ptr_inc(32'(r_tail), DEPTH));
      if (w_pop)  r_head <= PTR_W'(ptr_inc(32'(r_head), DEPTH));
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage. Contents are qualified by the valid mask, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= '{rd: in_rd, data: XLEN_DEFAULT'(in_data)};
  end

  // An entry is live when its distance from the head is below the count.
  always_comb begin
    logic [PTR_W-1:0] off;
    off     = '0;
    w_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off        = PTR_W'(i) - r_head;
      w_valid[i] = ({1'b0, off} < r_count);
    end
  end

  wbq_match #(.DEPTH(DEPTH), .XLEN(XLEN)) u_match_rs1 (
    .i_entries (r_mem),
    .i_valid   (w_valid),
    .i_head    (r_head),
    .i_query   (q_rs1),
    .o_hit     (hit_rs1)
`ifdef WBQ_FORWARD_EN
    ,
    .o_data    (fwd_rs1)
`endif
  );

  wbq_match #(.DEPTH(DEPTH), .XLEN(XLEN)) u_match_rs2 (
    .i_entries (r_mem),
    .i_valid   (w_valid),
    .i_head    (r_head),
    .i_query   (q_rs2),
    .o_hit     (hit_rs2)
`ifdef WBQ_FORWARD_EN
    ,
    .o_data    (fwd_rs2)
`endif
  );

endmodule

// File: tb/tb_wb_queue.sv
// Testbench for wb_queue: directed steps followed by random traffic,
// checked against a queue-based reference model.
module tb_wb_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        wb_stall;
  logic        wb_wen;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  q_rs1, q_rs2;
  logic        hit_rs1, hit_rs2;
`ifdef WBQ_FORWARD_EN
  logic [31:0] fwd_rs1, fwd_rs2;
`endif

  wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_rd    (in_rd),
    .in_data  (in_data),
    .wb_stall (wb_stall),
    .wb_wen   (wb_wen),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .q_rs1    (q_rs1),
    .q_rs2    (q_rs2),
    .hit_rs1  (hit_rs1),
    .hit_rs2  (hit_rs2)
`ifdef WBQ_FORWARD_EN
    ,
    .fwd_rs1  (fwd_rs1),
    .fwd_rs2  (fwd_rs2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t model[$];
  int   checks = 0;
  int   errors = 0;

  logic exp_ready, exp_wen;
  logic cur_valid;
  logic [4:0]  cur_rd;
  logic [31:0] cur_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Youngest pending write to q wins; x0 never matches.
  task automatic ref_hit(input logic [4:0] q, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (q != 0) begin
      for (int i = model.size() - 1; i >= 0; i--) begin
        if (model[i].rd == q) begin
          h = 1'b1;
          d = model[i].data;
          break;
        end
      end
    end
  endtask

  // Drive one cycle's inputs after the falling edge and compare all outputs.
  task automatic drv(input logic v, input logic [4:0] rd, input logic [31:0] d,
                     input logic st, input logic [4:0] a1, input logic [4:0] a2);
    logic h1, h2;
    logic [31:0] f1, f2;
    @(negedge clk);
    in_valid = v; in_rd = rd; in_data = d; wb_stall = st; q_rs1 = a1; q_rs2 = a2;
    cur_valid = v; cur_rd = rd; cur_data = d;
    #1;
    exp_ready = (model.size() != DEPTH);
    exp_wen   = (model.size() != 0) && !st;
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
    chk("wb_wen",   {31'b0, wb_wen},   {31'b0, exp_wen});
    chk("wb_addr",  {27'b0, wb_addr},  (model.size() != 0) ? {27'b0, model[0].rd} : 32'h0);
    chk("wb_data",  wb_data,           (model.size() != 0) ? model[0].data : 32'h0);
    ref_hit(a1, h1, f1);
    ref_hit(a2, h2, f2);
    chk("hit_rs1", {31'b0, hit_rs1}, {31'b0, h1});
    chk("hit_rs2", {31'b0, hit_rs2}, {31'b0, h2});
`ifdef WBQ_FORWARD_EN
    chk("fwd_rs1", fwd_rs1, f1);
    chk("fwd_rs2", fwd_rs2, f2);
`endif
  endtask

  // Advance the model across the rising edge.
  task automatic tick();
    @(posedge clk);
    if (exp_wen) void'(model.pop_front());
    if (cur_valid && exp_ready && cur_rd != 0) model.push_back('{rd: cur_rd, data: cur_data});
  endtask

  task automatic step(input logic v, input logic [4:0] rd, input logic [31:0] d,
                      input logic st, input logic [4:0] a1, input logic [4:0] a2);
    drv(v, rd, d, st, a1, a2);
    tick();
  endtask

  initial begin
    rst = 1'b0; in_valid = 0; in_rd = 0; in_data = 0; wb_stall = 0; q_rs1 = 5'd3; q_rs2 = 5'd4;
    cur_valid = 0; cur_rd = 0; cur_data = 0; exp_ready = 1; exp_wen = 0;
    #3;
    chk("rst_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_wen",   {31'b0, wb_wen},   32'h0);
    chk("rst_addr",  {27'b0, wb_addr},  32'h0);
    chk("rst_data",  wb_data,           32'h0);
    chk("rst_hits",  {30'b0, hit_rs1, hit_rs2}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Single push, no bypass in the push cycle, written the next cycle.
    drv(1, 5'd5, 32'hDEADBEEF, 0, 5'd5, 0);
    chk("t1_no_bypass", {31'b0, wb_wen}, 32'h0);
    tick();
    drv(0, 0, 0, 0, 5'd5, 0);
    chk("t1_wen",  {31'b0, wb_wen},  32'h1);
    chk("t1_addr", {27'b0, wb_addr}, 32'h5);
    chk("t1_data", wb_data,          32'hDEADBEEF);
    chk("t1_hit",  {31'b0, hit_rs1}, 32'h1);
    tick();
    drv(0, 0, 0, 0, 5'd5, 0);
    chk("t1_empty_wen", {31'b0, wb_wen}, 32'h0);
    tick();

    // Push to x0 stores nothing.
    step(1, 5'd0, 32'h1234, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0);
    chk("t2_wen",   {31'b0, wb_wen},   32'h0);
    chk("t2_ready", {31'b0, in_ready}, 32'h1);
    chk("t2_hit0",  {31'b0, hit_rs1},  32'h0);
    tick();

    // Fill under stall, then drain in order.
    for (int i = 1; i <= 4; i++) step(1, 5'(i), 32'hA0 + i, 1, 5'd2, 5'd4);
    drv(1, 5'd9, 32'h99, 1, 5'd1, 5'd3);
    chk("t3_full_ready", {31'b0, in_ready}, 32'h0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      drv(0, 0, 0, 0, 5'd4, 5'd9);
      chk("t3_drain_addr", {27'b0, wb_addr}, 32'(i));
      if (i == 2) chk("t3_ready_after_pop", {31'b0, in_ready}, 32'h1);
      tick();
    end

    // Duplicate rd: youngest forwarded, oldest written first.
    step(1, 5'd7, 32'h11, 1, 5'd7, 0);
    step(1, 5'd7, 32'h22, 1, 5'd7, 0);
    drv(0, 0, 0, 1, 5'd7, 5'd7);
    chk("t4_hit", {31'b0, hit_rs1}, 32'h1);
`ifdef WBQ_FORWARD_EN
    chk("t4_fwd", fwd_rs1, 32'h22);
`endif
    tick();
    drv(0, 0, 0, 0, 5'd7, 0);
    chk("t4_first", wb_data, 32'h11);
    tick();
    drv(0, 0, 0, 0, 5'd7, 0);
    chk("t4_second", wb_data, 32'h22);
    tick();
    drv(0, 0, 0, 0, 5'd7, 0);
    chk("t4_hit_clear", {31'b0, hit_rs1}, 32'h0);
    tick();

    // Steady push+pop at count 2 across pointer wrap.
    step(1, 5'd10, 32'h100, 1, 0, 0);
    step(1, 5'd11, 32'h101, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drv(1, 5'(12 + i), 32'h102 + i, 0, 5'(11 + i), 5'(12 + i));
      chk("t5_wen", {31'b0, wb_wen}, 32'h1);
      chk("t5_order", wb_data, 32'h100 + i);
      tick();
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

    // Reset mid-cycle with pending entries: all discarded.
    for (int i = 0; i < 3; i++) step(1, 5'(20 + i), 32'h200 + i, 1, 0, 0);
    #2;
    rst = 1'b0;
    q_rs1 = 5'd20; q_rs2 = 5'd22; wb_stall = 1'b0; in_valid = 1'b0;
    #1;
    chk("t6_rst_wen",   {31'b0, wb_wen},   32'h0);
    chk("t6_rst_addr",  {27'b0, wb_addr},  32'h0);
    chk("t6_rst_data",  wb_data,           32'h0);
    chk("t6_rst_hits",  {30'b0, hit_rs1, hit_rs2}, 32'h0);
    chk("t6_rst_ready", {31'b0, in_ready}, 32'h1);
    model.delete();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 5'(20 + i), 5'd21);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, 5'($urandom % 6), $urandom, ($urandom % 3) == 0,
           5'($urandom % 6), 5'($urandom % 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
